// File: rtl/messbauer_channel_sequencer_pkg.sv
// rtl/messbauer_channel_sequencer_pkg.sv - shared types, defaults and helpers for the channel sequencer
//
// Purpose : FSM state encoding, default frame geometry shared with the
//           saw-tooth generator and its benches, and a clog2 helper.
// Ports   : none (package).

package messbauer_channel_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEFAULT_CHANNEL_NUMBER = 512;
  localparam int DEFAULT_CHANNEL_PERIOD = 800;

  // Minimum width 1 so a degenerate value still yields a legal vector.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/messbauer_channel_sequencer_if.sv
// rtl/messbauer_channel_sequencer_if.sv - control/strobe bundle between host, sequencer and saw-tooth generator
//
// Purpose : groups the run control inputs and the timing outputs.
// Signals : enable, frames_req        host -> sequencer
//           start, channel             frame / channel strobes
//           channel_index, frame_count position and progress
//           busy, done                 run status
// Modports: master = host/test side, slave = sequencer side.

interface messbauer_channel_sequencer_if #(
  parameter int INDEX_W       = 9,
  parameter int FRAME_COUNT_W = 16
);

  logic                     enable;
  logic [FRAME_COUNT_W-1:0] frames_req;
  logic                     start;
  logic                     channel;
  logic [INDEX_W-1:0]       channel_index;
  logic [FRAME_COUNT_W-1:0] frame_count;
  logic                     busy;
  logic                     done;

  modport master (
    output enable, frames_req,
    input  start, channel, channel_index, frame_count, busy, done
  );

  modport slave (
    input  enable, frames_req,
    output start, channel, channel_index, frame_count, busy, done
  );

endinterface

// File: rtl/messbauer_slot_timer.sv
// rtl/messbauer_slot_timer.sv - period counter that ticks at the last clock of each channel slot
//
// Purpose : counts 0..PERIOD-1 while enabled and wraps; clear forces 0.
// Ports   : aclk, areset_n  clock, asynchronous active-low reset
//           clear           synchronous clear (wins over en)
//           en              advance the count this clock
//           count           current count (registered)
//           slot_end        high while en and count == PERIOD-1

module messbauer_slot_timer #(
  parameter int PERIOD = 800,
  parameter int W      = 10
) (
  input  logic         aclk,
  input  logic         areset_n,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         slot_end
);

  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign slot_end = en && (count_q == LAST);

endmodule

// File: rtl/messbauer_channel_sequencer.sv
// rtl/messbauer_channel_sequencer.sv - frame/channel timing master for the Messbauer environment
//
// Purpose : steps the saw-tooth generator through CHANNEL_NUMBER slots per
//           frame, runs frames_req frames (0 = free-run) per enable rising edge.
// Ports   : aclk, areset_n  clock, asynchronous active-low reset
//           seq (slave)     enable/frames_req in; start, channel,
//                           channel_index, frame_count, busy, done out
// All outputs are registered; they are decoded from next-state values so
// they change on the same edge as the state they describe.

module messbauer_channel_sequencer
  import messbauer_channel_sequencer_pkg::*;
#(
  parameter int CHANNEL_NUMBER = DEFAULT_CHANNEL_NUMBER,
  parameter int CHANNEL_PERIOD = DEFAULT_CHANNEL_PERIOD,
  parameter int CHANNEL_WIDTH  = 2,
  parameter int START_WIDTH    = 4,
  parameter int FRAME_COUNT_W  = 16
) (
  input  logic                          aclk,
  input  logic                          areset_n,
  messbauer_channel_sequencer_if.slave  seq
);

  localparam int IW = clog2(CHANNEL_NUMBER);
  localparam int TW = clog2(CHANNEL_PERIOD);
  localparam int FW = FRAME_COUNT_W;

  localparam logic [IW-1:0] LAST_INDEX = IW'(CHANNEL_NUMBER - 1);
  // One extra bit so START_WIDTH == CHANNEL_PERIOD still compares correctly.
  localparam logic [TW:0]   CH_LIMIT   = (TW + 1)'(CHANNEL_WIDTH);
  localparam logic [TW:0]   ST_LIMIT   = (TW + 1)'(START_WIDTH);

  state_e        state_q, state_d;
  logic [IW-1:0] index_q, index_d;
  logic [FW-1:0] frame_count_q, frame_count_d;
  logic [FW-1:0] frames_req_q, frames_req_d;
  logic          enable_prev_q;
  logic          start_q, start_d;
  logic          channel_q, channel_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          tmr_clear;
  logic          tmr_en;
  logic [TW-1:0] tmr_count;
  logic [TW-1:0] tmr_next;
  logic          slot_end;
  logic          stop;

  messbauer_slot_timer #(
    .PERIOD (CHANNEL_PERIOD),
    .W      (TW)
  ) u_slot_timer (
    .aclk     (aclk),
    .areset_n (areset_n),
    .clear    (tmr_clear),
    .en       (tmr_en),
    .count    (tmr_count),
    .slot_end (slot_end)
  );

  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    frame_count_d = frame_count_q;
    frames_req_d  = frames_req_q;
    tmr_clear     = 1'b0;
    tmr_en        = 1'b0;
    stop          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (seq.enable && !enable_prev_q) begin
          frames_req_d  = seq.frames_req;
          frame_count_d = '0;
          index_d       = '0;
          tmr_clear     = 1'b1;
          state_d       = ST_RUN;
        end
      end
      ST_RUN: begin
        tmr_en = 1'b1;
        if (slot_end) begin
          if (index_q == LAST_INDEX) begin
            index_d       = '0;
            frame_count_d = frame_count_q + FW'(1);
            // enable is only looked at here, so mid-frame glitches are ignored.
            stop = !seq.enable ||
                   ((frames_req_q != '0) && (frame_count_d == frames_req_q));
            if (stop) begin
              state_d = ST_DONE;
            end
          end else begin
            index_d = index_q + IW'(1);
          end
        end
      end
      ST_DONE: begin
        index_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Mirror of the slot timer's next count, used to decode the strobes.
    if (tmr_clear || slot_end) begin
      tmr_next = '0;
    end else if (tmr_en) begin
      tmr_next = tmr_count + TW'(1);
    end else begin
      tmr_next = tmr_count;
    end

    busy_d    = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
    channel_d = busy_d && ({1'b0, tmr_next} < CH_LIMIT);
    start_d   = busy_d && (index_d == '0) && ({1'b0, tmr_next} < ST_LIMIT);
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q       <= ST_IDLE;
      index_q       <= '0;
      frame_count_q <= '0;
      frames_req_q  <= '0;
      enable_prev_q <= 1'b0;
      start_q       <= 1'b0;
      channel_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      frame_count_q <= frame_count_d;
      frames_req_q  <= frames_req_d;
      enable_prev_q <= seq.enable;
      start_q       <= start_d;
      channel_q     <= channel_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign seq.start         = start_q;
  assign seq.channel       = channel_q;
  assign seq.channel_index = index_q;
  assign seq.frame_count   = frame_count_q;
  assign seq.busy          = busy_q;
  assign seq.done          = done_q;

endmodule
